cim_ctrl: RTL and testbench

CIM_CTRL -- requirements
Module: cim_ctrl

---
 rtl/cim_ctrl_if.sv | 22 ++
 rtl/cim_ctrl.sv | 86 ++++++++
 tb/tb_cim_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cim_ctrl_if.sv
// cim_ctrl_if: host command and result handshake bundle for cim_ctrl.
interface cim_ctrl_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_addr;
  logic [31:0]  cmd_data;
  logic [15:0]  cmd_sel;
  logic         cmd_model;
  logic [3:0]   cmd_nbits;
  logic         res_valid;
  logic         res_ready;
  logic [191:0] res_data;
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_sel, cmd_model, cmd_nbits, res_ready,
    input  cmd_ready, res_valid, res_data
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_sel, cmd_model, cmd_nbits, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/cim_ctrl.sv
// cim_ctrl: sequences WRITE/COMPUTE/CLEAR commands onto a compute-in-memory macro.
// Define CIM_CTRL_ACC_EN to accumulate results per 16-bit lane and enable CLEAR.
module cim_ctrl (
  input  logic          clk,
  input  logic          rst,
  cim_ctrl_if.slave     bus,
  output logic [7:0]    cim_a,
  output logic [31:0]   cim_d,
  output logic [15:0]   cim_sel_array,
  output logic          cim_model,
  output logic          cim_wrt,
  output logic          cim_col_en,
  output logic          cim_set,
  output logic          cim_comp,
  output logic          cim_inbit,
  output logic          cim_reg_en,
  output logic          cim_wait,
  input  logic [191:0]  cim_q
);
  typedef enum logic [2:0] {IDLE, WRITE, SET, BIT, DRAIN, CAPTURE, RESP} state_t;
  state_t state, state_nx;
  logic [3:0]   nbits, cnt;
  logic         drain, accept;
  logic [191:0] res_q, res_nx;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign bus.cmd_ready = state == IDLE;
  assign bus.res_valid = state == RESP;
  assign bus.res_data  = res_q;
  assign cim_wrt       = state == WRITE;
  assign cim_col_en    = state == WRITE;
  assign cim_set       = state == SET;
  assign cim_reg_en    = state == BIT;
  assign cim_comp      = state == BIT || state == DRAIN;
  assign cim_wait      = state == DRAIN;
  assign cim_inbit     = state == BIT && cim_d[{1'b0, cnt}];
`ifdef CIM_CTRL_ACC_EN
  always_comb begin
    res_nx = '0;
    for (int i = 0; i < 12; i++) res_nx[i*16 +: 16] = res_q[i*16 +: 16] + cim_q[i*16 +: 16];
  end
`else
  assign res_nx = cim_q;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !accept ? IDLE : bus.cmd_op == 2'b00 ? WRITE : bus.cmd_op == 2'b01 ? SET : IDLE;
      WRITE:   state_nx = IDLE;
      SET:     state_nx = BIT;
      BIT:     state_nx = cnt == nbits - 4'd1 ? DRAIN : BIT;
      DRAIN:   state_nx = drain ? CAPTURE : DRAIN;
      CAPTURE: state_nx = RESP;
      RESP:    state_nx = bus.res_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // nbits of 0 wraps nbits-1 to 15, giving the 16-bit case for free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      drain         <= 1'b0;
      nbits         <= '0;
      cim_a         <= '0;
      cim_d         <= '0;
      cim_sel_array <= '0;
      cim_model     <= 1'b0;
      res_q         <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == BIT && cnt != nbits - 4'd1) ? cnt + 4'd1 : 4'd0;
      drain <= state == DRAIN && !drain;
      if (accept) begin
        cim_a         <= bus.cmd_addr;
        cim_d         <= bus.cmd_data;
        cim_sel_array <= bus.cmd_sel;
        cim_model     <= bus.cmd_model;
        nbits         <= bus.cmd_nbits;
      end
      if (state == CAPTURE) res_q <= res_nx;
`ifdef CIM_CTRL_ACC_EN
      if (accept && bus.cmd_op == 2'b11) res_q <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_cim_ctrl.sv
// tb_cim_ctrl: directed self-checking bench for cim_ctrl (both CIM_CTRL_ACC_EN builds).
module tb_cim_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   cim_a;
  logic [31:0]  cim_d;
  logic [15:0]  cim_sel_array;
  logic         cim_model, cim_wrt, cim_col_en, cim_set, cim_comp, cim_inbit, cim_reg_en, cim_wait;
  logic [191:0] cim_q = '0;
  logic [191:0] model = '0;
  logic [6:0]   strobes;
  int checks = 0;
  int errors = 0;
  cim_ctrl_if bus ();
  cim_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cim_a(cim_a), .cim_d(cim_d), .cim_sel_array(cim_sel_array), .cim_model(cim_model),
    .cim_wrt(cim_wrt), .cim_col_en(cim_col_en), .cim_set(cim_set), .cim_comp(cim_comp),
    .cim_inbit(cim_inbit), .cim_reg_en(cim_reg_en), .cim_wait(cim_wait), .cim_q(cim_q)
  );
  always #5 clk = ~clk;
  assign strobes = {cim_wrt, cim_col_en, cim_set, cim_comp, cim_inbit, cim_reg_en, cim_wait};

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                       input logic [15:0] sel, input logic mdl, input logic [3:0] nb);
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d;
    bus.cmd_sel = sel; bus.cmd_model = mdl; bus.cmd_nbits = nb;
    bus.cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  function automatic logic [191:0] lanes(input logic [15:0] v);
    for (int i = 0; i < 12; i++) lanes[i*16 +: 16] = v;
  endfunction

  // full COMPUTE walk: every cycle's strobes, result timing, data and optional back-pressure
  task automatic run_compute(input logic [3:0] nb, input logic [31:0] d, input logic [191:0] q, input int hold);
    int n;
    logic [191:0] held;
    n = (nb == 4'd0) ? 16 : int'(nb);
    cim_q = q;
    issue(2'b01, 8'h11, d, 16'h00FF, 1'b0, nb);
    chk("set", strobes, 7'b0010000);
    for (int k = 0; k < n; k++) begin
      tick();
      chk($sformatf("bit%0d", k), strobes, {4'b0001, d[k], 2'b10});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("drain", strobes, 7'b0001001);
    end
    tick();
    chk("capture", {strobes, bus.res_valid}, 8'h00);
    tick();
`ifdef CIM_CTRL_ACC_EN
    for (int i = 0; i < 12; i++) model[i*16 +: 16] = model[i*16 +: 16] + q[i*16 +: 16];
`else
    model = q;
`endif
    chk("res_valid_edge", bus.res_valid, 1'b1);
    chk("res_data", bus.res_data, model);
    chk("cmd_ready_in_resp", bus.cmd_ready, 1'b0);
    held = bus.res_data;
    cim_q = ~q;
    bus.cmd_valid = hold > 0;
    bus.cmd_op = 2'b00;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", {bus.res_valid, bus.cmd_ready, strobes}, {2'b10, 7'b0});
      chk("hold_data", bus.res_data, held);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("back_to_idle", {bus.res_valid, bus.cmd_ready, strobes}, {2'b01, 7'b0});
    chk("res_data_after_hs", bus.res_data, held);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.cmd_sel = '0; bus.cmd_model = 1'b0; bus.cmd_nbits = '0; bus.res_ready = 1'b0;
    tick();
    tick();
    chk("reset_strobes", strobes, 7'b0);
    chk("reset_regs", {cim_a, cim_d, cim_sel_array, cim_model}, 57'b0);
    chk("reset_res", {bus.res_valid, bus.res_data}, 193'b0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", bus.cmd_ready, 1'b1);
    // WRITE
    issue(2'b00, 8'h3C, 32'hDEADBEEF, 16'hA5A5, 1'b1, 4'd3);
    chk("write_strobes", strobes, 7'b1100000);
    chk("write_regs", {cim_a, cim_d, cim_sel_array, cim_model}, {8'h3C, 32'hDEADBEEF, 16'hA5A5, 1'b1});
    chk("write_busy", bus.cmd_ready, 1'b0);
    tick();
    chk("write_done", {bus.cmd_ready, bus.res_valid, strobes}, {2'b10, 7'b0});
    chk("write_regs_held", {cim_a, cim_d}, {8'h3C, 32'hDEADBEEF});
    // reserved op: no strobes, no result, ready again
    issue(2'b10, 8'h01, 32'hFFFFFFFF, 16'h1, 1'b0, 4'd2);
    chk("reserved_idle", {bus.cmd_ready, bus.res_valid, strobes}, {2'b10, 7'b0});
    tick();
    chk("reserved_quiet", {bus.cmd_ready, bus.res_valid, strobes}, {2'b10, 7'b0});
    // COMPUTE nbits=4, bits 1,1,0,1
    run_compute(4'd4, 32'h0000000B, {192{1'b1}}, 0);
    // COMPUTE nbits=0 -> 16 bit cycles, back-pressured 5 cycles with cmd_valid high
    run_compute(4'd0, 32'h0000A5C3, {12{16'h1234}}, 5);
    // reset during BIT cycle 2
    cim_q = {192{1'b1}};
    issue(2'b01, 8'h22, 32'hFFFFFFFF, 16'hFFFF, 1'b1, 4'd8);
    tick();
    tick();
    tick();
    chk("in_bit2", strobes, 7'b0001110);
    rst = 1'b1;
    #1;
    model = '0;
    chk("reset_mid_strobes", strobes, 7'b0);
    chk("reset_mid_res", {bus.res_valid, bus.res_data}, 193'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_reset_quiet", {bus.res_valid, bus.cmd_ready, strobes}, {2'b01, 7'b0});
    end
    issue(2'b00, 8'h55, 32'h12345678, 16'h0F0F, 1'b0, 4'd1);
    chk("post_reset_write", {strobes, cim_a}, {7'b1100000, 8'h55});
    tick();
    // CLEAR then two COMPUTEs with lanes 0x8001
    issue(2'b11, 8'h00, 32'h0, 16'h0, 1'b0, 4'd0);
`ifdef CIM_CTRL_ACC_EN
    model = '0;
`endif
    chk("clear_idle", {bus.cmd_ready, bus.res_valid, strobes}, {2'b10, 7'b0});
    chk("clear_res", bus.res_data, model);
    run_compute(4'd2, 32'h00000002, lanes(16'h8001), 0);
    chk("acc_first", bus.res_data, lanes(16'h8001));
    run_compute(4'd1, 32'h00000001, lanes(16'h8001), 0);
`ifdef CIM_CTRL_ACC_EN
    chk("acc_wrap", bus.res_data, lanes(16'h0002));
`else
    chk("overwrite", bus.res_data, lanes(16'h8001));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
